// File: rtl/stack_row_engine_pkg.sv
// rtl/stack_row_engine_pkg.sv - shared stacker types, widths and level-input helpers
package stacker_pkg;

  localparam int SPEED_W = 4;
  localparam int NBLK_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOVE,
    ST_RESOLVE,
    ST_OVER
  } state_e;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_e;

  // Speed 0 is not a legal level speed; run it as the slowest speed.
  function automatic logic [SPEED_W-1:0] speed_eff(input logic [SPEED_W-1:0] s);
    return (s == '0) ? SPEED_W'(1) : s;
  endfunction

  // A zero-width segment would be unplayable; run it as a single cell.
  function automatic logic [NBLK_W-1:0] num_blocks_eff(input logic [NBLK_W-1:0] n);
    return (n == '0) ? NBLK_W'(1) : n;
  endfunction

endpackage

// File: rtl/stack_row_engine_if.sv
// rtl/stack_row_engine_if.sv - player/level inputs and row display outputs of the engine
interface stack_row_engine_if #(
  parameter int COLS = 8
);
  import stacker_pkg::*;

  logic                 start;
  logic                 place;
  logic [SPEED_W-1:0]   speed;
  logic [NBLK_W-1:0]    num_blocks;
  logic [COLS-1:0]      row_mask;
  logic [COLS-1:0]      prev_mask;
  logic [4:0]           row_count;
  logic                 next_signal;
  logic                 fail;
  logic                 win;
  logic                 busy;

  modport slave (
    input  start, place, speed, num_blocks,
    output row_mask, prev_mask, row_count, next_signal, fail, win, busy
  );

  modport master (
    output start, place, speed, num_blocks,
    input  row_mask, prev_mask, row_count, next_signal, fail, win, busy
  );

endinterface

// File: rtl/stack_row_engine_step_ticker.sv
// rtl/stack_row_engine_step_ticker.sv - speed-dependent step pulse generator
module step_ticker
  import stacker_pkg::*;
#(
  parameter int TICK_BASE = 2500000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               enable_i,
  output logic               step_o
);

  localparam int CW = $clog2(TICK_BASE * 15 + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] period_m1;

  // Period follows speed live; >= keeps a shortened period from waiting for a wrap.
  always_comb begin
    period_m1 = CW'(TICK_BASE * (16 - int'(speed_eff(speed_i))) - 1);
    step_o    = enable_i && (cnt_q >= period_m1);
  end

  // Count cycles while enabled, restart on each step or whenever disabled.
  always_ff @(posedge clk) begin
    if (!resetn || !enable_i) begin
      cnt_q <= '0;
    end else if (cnt_q >= period_m1) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/stack_row_engine.sv
// rtl/stack_row_engine.sv - sweeping segment, placement resolution and game progress
module stack_row_engine
  import stacker_pkg::*;
#(
  parameter int COLS      = 8,
  parameter int ROWS      = 12,
  parameter int TICK_BASE = 2500000
) (
  input  logic                clk,
  input  logic                resetn,
  stack_row_engine_if.slave   bus
);

  state_e          state_q;
  dir_e            dir_q;
  dir_e            dir_d;
  logic [4:0]      pos_q;
  logic [4:0]      pos_d;
  logic [4:0]      w_q;
  logic [4:0]      w_load_d;
  logic [4:0]      cw_q;
  logic [COLS-1:0] row_mask_q;
  logic [COLS-1:0] prev_mask_q;
  logic [COLS-1:0] ov_d;
  logic [4:0]      row_count_q;
  logic [4:0]      row_count_d;
  logic            next_q;
  logic            fail_q;
  logic            win_q;
  logic            busy_q;
  logic            step;

  function automatic logic [COLS-1:0] mask_of(input logic [4:0] w, input logic [4:0] pos);
    logic [31:0] m;
    m = ((32'd1 << w) - 32'd1) << pos;
    return m[COLS-1:0];
  endfunction

  function automatic logic [4:0] popcount(input logic [COLS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < COLS; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  step_ticker #(
    .TICK_BASE(TICK_BASE)
  ) u_ticker (
    .clk      (clk),
    .resetn   (resetn),
    .speed_i  (bus.speed),
    .enable_i (state_q == ST_MOVE),
    .step_o   (step)
  );

  // Segment width for the next row, overlap of the current drop and the next sweep position.
  always_comb begin
    logic [4:0] nbe;
    logic [4:0] lim;
    nbe = 5'(num_blocks_eff(bus.num_blocks));
    if (row_count_q == '0) begin
      lim = nbe;
    end else begin
      lim = (nbe < cw_q) ? nbe : cw_q;
    end
    w_load_d    = (lim > 5'(COLS)) ? 5'(COLS) : lim;
    ov_d        = row_mask_q & prev_mask_q;
    row_count_d = row_count_q + 5'd1;

    pos_d = pos_q;
    dir_d = dir_q;
    if (w_q >= 5'(COLS)) begin
      pos_d = '0;
    end else if (dir_q == DIR_RIGHT) begin
      if ((6'(pos_q) + 6'(w_q) + 6'd1) > 6'(COLS)) begin
        dir_d = DIR_LEFT;
        pos_d = pos_q - 5'd1;
      end else begin
        pos_d = pos_q + 5'd1;
      end
    end else begin
      if (pos_q == '0) begin
        dir_d = DIR_RIGHT;
        pos_d = pos_q + 5'd1;
      end else begin
        pos_d = pos_q - 5'd1;
      end
    end
  end

  // Game FSM with all display and pulse outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      pos_q       <= '0;
      w_q         <= '0;
      cw_q        <= '0;
      row_mask_q  <= '0;
      prev_mask_q <= '1;
      row_count_q <= '0;
      next_q      <= 1'b0;
      fail_q      <= 1'b0;
      win_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      next_q <= 1'b0;
      fail_q <= 1'b0;
      win_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          w_q        <= w_load_d;
          pos_q      <= '0;
          dir_q      <= DIR_RIGHT;
          row_mask_q <= mask_of(w_load_d, 5'd0);
          state_q    <= ST_MOVE;
        end
        ST_MOVE: begin
          // A drop on a step cycle resolves the mask the player actually saw.
          if (bus.place) begin
            state_q <= ST_RESOLVE;
          end else if (step) begin
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            row_mask_q <= mask_of(w_q, pos_d);
          end
        end
        ST_RESOLVE: begin
          if (ov_d != '0) begin
            prev_mask_q <= ov_d;
            cw_q        <= popcount(ov_d);
            row_count_q <= row_count_d;
            next_q      <= 1'b1;
            if (row_count_d == 5'(ROWS)) begin
              win_q   <= 1'b1;
              state_q <= ST_OVER;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
            end
          end else begin
            fail_q  <= 1'b1;
            state_q <= ST_OVER;
            busy_q  <= 1'b0;
          end
        end
        ST_OVER: begin
          if (bus.start) begin
            row_count_q <= '0;
            prev_mask_q <= '1;
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row_mask    = row_mask_q;
  assign bus.prev_mask   = prev_mask_q;
  assign bus.row_count   = row_count_q;
  assign bus.next_signal = next_q;
  assign bus.fail        = fail_q;
  assign bus.win         = win_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_stack_row_engine.sv
// tb/tb_stack_row_engine.sv - directed self-checking bench for stack_row_engine
module tb_stack_row_engine;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_pass;

  stack_row_engine_if #(.COLS(8)) bus_if ();

  stack_row_engine #(
    .COLS      (8),
    .ROWS      (3),
    .TICK_BASE (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn            = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.place      = 1'b0;
    bus_if.speed      = 4'd15;
    bus_if.num_blocks = 3'd3;
    step(3);
    check("rst_row_mask",  32'(bus_if.row_mask),    32'h00);
    check("rst_prev_mask", 32'(bus_if.prev_mask),   32'hFF);
    check("rst_row_count", 32'(bus_if.row_count),   32'd0);
    check("rst_next",      32'(bus_if.next_signal), 32'd0);
    check("rst_fail",      32'(bus_if.fail),        32'd0);
    check("rst_win",       32'(bus_if.win),         32'd0);
    check("rst_busy",      32'(bus_if.busy),        32'd0);
    resetn = 1'b1;
    step(1);

    // Basic sweep, speed 15 -> step every 2 cycles
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    check("load_busy", 32'(bus_if.busy), 32'd1);
    check("load_pre_mask", 32'(bus_if.row_mask), 32'h00);
    step(1); check("sweep_07", 32'(bus_if.row_mask), 32'h07);
    step(1); check("sweep_07_hold", 32'(bus_if.row_mask), 32'h07);
    step(1); check("sweep_0e", 32'(bus_if.row_mask), 32'h0E);
    step(2); check("sweep_1c", 32'(bus_if.row_mask), 32'h1C);
    step(2); check("sweep_38", 32'(bus_if.row_mask), 32'h38);
    step(2); check("sweep_70", 32'(bus_if.row_mask), 32'h70);
    step(2); check("sweep_e0", 32'(bus_if.row_mask), 32'hE0);
    step(2); check("bounce_right", 32'(bus_if.row_mask), 32'h70);
    step(2); check("left_38", 32'(bus_if.row_mask), 32'h38);
    step(2); check("left_1c", 32'(bus_if.row_mask), 32'h1C);

    // Slowest speed: 30-cycle step period
    bus_if.speed = 4'd1;
    step(29); check("slow_hold_1c", 32'(bus_if.row_mask), 32'h1C);
    step(1);  check("slow_step_0e", 32'(bus_if.row_mask), 32'h0E);
    step(29); check("slow_hold_0e", 32'(bus_if.row_mask), 32'h0E);
    step(1);  check("slow_step_07", 32'(bus_if.row_mask), 32'h07);
    bus_if.speed = 4'd15;
    step(2); check("bounce_left", 32'(bus_if.row_mask), 32'h0E);
    step(2); check("right_again_1c", 32'(bus_if.row_mask), 32'h1C);

    // First placement at 0x1C
    bus_if.place = 1'b1;
    step(1);
    bus_if.place = 1'b0;
    check("place1_n1_next", 32'(bus_if.next_signal), 32'd0);
    step(1);
    check("place1_next", 32'(bus_if.next_signal), 32'd1);
    check("place1_fail", 32'(bus_if.fail), 32'd0);
    check("place1_win", 32'(bus_if.win), 32'd0);
    check("place1_prev", 32'(bus_if.prev_mask), 32'h1C);
    check("place1_count", 32'(bus_if.row_count), 32'd1);
    step(1);
    check("row2_mask", 32'(bus_if.row_mask), 32'h07);
    check("place1_pulse_end", 32'(bus_if.next_signal), 32'd0);
    step(2); check("row2_0e", 32'(bus_if.row_mask), 32'h0E);

    // Second placement trims to 0x0C
    bus_if.place = 1'b1;
    step(1);
    bus_if.place = 1'b0;
    step(1);
    check("place2_next", 32'(bus_if.next_signal), 32'd1);
    check("place2_prev", 32'(bus_if.prev_mask), 32'h0C);
    check("place2_count", 32'(bus_if.row_count), 32'd2);
    step(1);
    check("row3_trim_mask", 32'(bus_if.row_mask), 32'h03);

    // Place on a step cycle: pre-step 0x03 misses 0x0C (post-step 0x06 would hit)
    step(1);
    bus_if.place = 1'b1;
    step(1);
    bus_if.place = 1'b0;
    step(1);
    check("miss_fail", 32'(bus_if.fail), 32'd1);
    check("miss_next", 32'(bus_if.next_signal), 32'd0);
    check("miss_count", 32'(bus_if.row_count), 32'd2);
    check("miss_busy", 32'(bus_if.busy), 32'd0);
    step(3);
    check("over_mask_held", 32'(bus_if.row_mask), 32'h03);
    check("over_fail_end", 32'(bus_if.fail), 32'd0);

    // place outside MOVE is ignored
    bus_if.place = 1'b1;
    step(1);
    bus_if.place = 1'b0;
    step(2);
    check("over_place_next", 32'(bus_if.next_signal), 32'd0);
    check("over_place_fail", 32'(bus_if.fail), 32'd0);
    check("over_place_mask", 32'(bus_if.row_mask), 32'h03);

    // Restart from OVER, width 4, three hits -> win
    bus_if.num_blocks = 3'd4;
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    check("restart_count", 32'(bus_if.row_count), 32'd0);
    check("restart_prev", 32'(bus_if.prev_mask), 32'hFF);
    check("restart_busy", 32'(bus_if.busy), 32'd1);
    step(1);
    check("restart_mask", 32'(bus_if.row_mask), 32'h0F);
    for (int i = 1; i <= 3; i++) begin
      bus_if.place = 1'b1;
      step(1);
      bus_if.place = 1'b0;
      step(1);
      check("win_seq_next", 32'(bus_if.next_signal), 32'd1);
      check("win_seq_count", 32'(bus_if.row_count), 32'(i));
      check("win_seq_win", 32'(bus_if.win), (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) begin
        step(1);
        check("win_seq_mask", 32'(bus_if.row_mask), 32'h0F);
      end
    end
    check("win_busy", 32'(bus_if.busy), 32'd0);
    step(1);
    check("win_pulse_end", 32'(bus_if.win), 32'd0);
    check("win_mask_held", 32'(bus_if.row_mask), 32'h0F);

    // Reset in the middle of MOVE
    bus_if.num_blocks = 3'd3;
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    step(1);
    check("g3_mask", 32'(bus_if.row_mask), 32'h07);
    bus_if.place = 1'b1;
    step(1);
    bus_if.place = 1'b0;
    step(1);
    check("g3_count", 32'(bus_if.row_count), 32'd1);
    step(2);
    resetn = 1'b0;
    step(1);
    check("mrst_row_mask",  32'(bus_if.row_mask),    32'h00);
    check("mrst_prev_mask", 32'(bus_if.prev_mask),   32'hFF);
    check("mrst_row_count", 32'(bus_if.row_count),   32'd0);
    check("mrst_busy",      32'(bus_if.busy),        32'd0);
    check("mrst_next",      32'(bus_if.next_signal), 32'd0);
    resetn = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_row_engine.md
Name: stack_row_engine

Overview:
- Gameplay core of the block stacker, at the opposite end of the level/difficulty controller.
- Consumes the level's speed and num_blocks and sweeps a block segment back and forth across the current row.
- On a player place press, intersects the segment with the row below and reports the outcome.
- A successful placement asserts next_signal, which advances the level controller. A miss asserts fail and ends the game.

Parameters:
- COLS, 8, row width in cells; 2..16.
- ROWS, 12, successful placements needed to win.
- TICK_BASE, 2500000, clock cycles per speed unit; step period = TICK_BASE*(16-speed_eff).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER
- place  in  1  one-cycle pulse (debounced upstream); player drops the segment
- speed  in  4  level speed 1..15; 0 treated as 1
- num_blocks  in  3  level segment width 1..7; 0 treated as 1; clipped to COLS
- row_mask  out  COLS  cells lit on the moving row; bit0 = leftmost
- prev_mask  out  COLS  cells of the last placed row; all ones before the first placement
- row_count  out  5  successful placements this game
- next_signal  out  1  one-cycle pulse: placement overlapped
- fail  out  1  one-cycle pulse: placement missed entirely
- win  out  1  one-cycle pulse: ROWS-th successful placement
- busy  out  1  high in LOAD/MOVE/RESOLVE

Behaviour:
- Reset (resetn low at a clk edge):
  - state=IDLE; row_mask=0; prev_mask=all ones; row_count=0.
  - next_signal, fail, win and busy are all 0.
  - Tick counter, pos and dir are cleared.
  - Reset overrides every other input, including mid-MOVE and mid-RESOLVE.
- States:
  - IDLE: start -> LOAD.
  - LOAD: one cycle; w = min(width limit, COLS); pos=0; dir=right; tick counter=0; -> MOVE. The width limit is num_blocks_eff for the first row, and min(num_blocks_eff, carry width) afterwards.
  - MOVE: row_mask = ((1<<w)-1)<<pos, updated registered. When the tick counter reaches the period-1, it clears and pos steps one cell in dir. place -> RESOLVE.
  - RESOLVE: one cycle; ov = row_mask & prev_mask.
    - ov != 0: prev_mask=ov, carry width=popcount(ov), row_count+1, next_signal pulse. If the new row_count == ROWS, also win -> OVER; else -> LOAD.
    - ov == 0: fail pulse -> OVER.
  - OVER: row_mask and prev_mask hold for display. start -> clears row_count, sets prev_mask to all ones, -> LOAD.
- Latency:
  - place sampled in cycle N.
  - Result pulse (next_signal, fail, win) is registered and high in cycle N+2 for exactly one cycle.
  - The new row_mask appears in N+3.
- Bounce:
  - A step that would put pos+w > COLS (moving right) or pos < 0 (moving left) instead flips dir and steps one cell the other way in the same tick.
  - If w == COLS, pos stays 0.
- Simultaneous events:
  - place and step tick in the same cycle: place wins; the pre-step mask is resolved.
  - place outside MOVE is ignored.
  - start outside IDLE/OVER is ignored.
- Level changes: speed is sampled continuously, so a change takes effect at the next tick compare. num_blocks is sampled only in LOAD.
- Arithmetic: step period computed as TICK_BASE*(16-speed_eff) in a counter wide enough for TICK_BASE*15.
- No combinational path from any input to any output.

Decomposition:
- Shared package stacker_pkg holds:
  - state enum (IDLE, LOAD, MOVE, RESOLVE, OVER);
  - speed/num_blocks widths (4/3);
  - speed_eff/num_blocks_eff helper functions.
- The level controller uses the same widths.
- One natural sub-module, step_ticker: takes speed and enable, emits a one-cycle step pulse every TICK_BASE*(16-speed_eff) cycles, and restarts when enable is low.
- Popcount stays an inline function.

Test Plan (COLS=8, ROWS=3, TICK_BASE=2):
- Basic sweep: reset, start, speed=15, num_blocks=3 -> row_mask 0x07 after LOAD, then 0x0E two cycles later, then 0x1C.
- Right-edge bounce: run until row_mask=0xE0 -> next step 0x70.
- Speed change: speed=1 -> steps 30 cycles apart.
- First placement and trim:
  - place at 0x1C -> next_signal in N+2, prev_mask=0x1C, row_count=1.
  - Next row starts at 0x07; place at 0x0E -> ov=0x0C, next_signal, next row mask 0x03.
- Miss: place with no overlap -> fail pulse, no next_signal, state OVER, row_mask held. start -> row_count=0, prev_mask=0xFF.
- Win: three overlapping placements -> third next_signal coincides with a win pulse, then OVER.
- Boundary events:
  - place on the same cycle as a step tick -> the pre-step mask is resolved.
  - resetn low during MOVE -> next cycle all outputs at reset values.
